ram_uart_tx: RTL
================

Name: ram_uart_tx

Overview:
- Reads a contiguous byte range out of data_ram (byte-wide, 16-bit address, synchronous read) and serialises each byte onto a UART TX line, 8N1, LSB first.
- Return path of the UART link: the receive side fills data_ram; this block dumps it back to the host.
- Sits beside data_ram and drives that RAM's port-A address/write-enable while it is busy.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 8, RAM data width and UART character width.
- CLKS_PER_BIT, 434, clka cycles per UART bit (50 MHz / 115200).
- RD_LAT, 1, RAM read latency in cycles from address at the RAM input to valid douta.

Ports:
- clka  in  1  system clock, rising edge.
- rsta  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_addr  in  ADDR_W  first address, captured on start.
- end_addr  in  ADDR_W  last address (inclusive), captured on start.
- ram_addra  out  ADDR_W  address to data_ram port A.
- ram_wea  out  1  write enable to data_ram; tied 0.
- ram_douta  in  DATA_W  read data from data_ram.
- tx  out  1  UART serial line; idles high.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last stop bit.

Behaviour:
- Reset (rsta=0, asynchronous): state IDLE, tx=1, busy=0, done=0, ram_addra=0, ram_wea=0, all counters 0. Reset asserted mid-character aborts at once: tx returns to 1 and no done pulse is issued.
- FSM states: IDLE, RD_WAIT, LOAD, START, DATA, STOP, NEXT.
- IDLE to RD_WAIT: on start=1. Capture start_addr into ram_addra and end_addr into an internal register. Set busy=1. Load the remaining-byte counter with ((end_addr - start_addr) mod 2^ADDR_W) + 1; the counter is ADDR_W+1 bits wide, so the range is 1..65536.
- RD_WAIT: hold for RD_LAT cycles, then go to LOAD.
- LOAD: shift_reg <= ram_douta; go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, shift_reg[0] first, each held CLKS_PER_BIT cycles; a bit index counts 0..7.
- STOP: tx=1 for CLKS_PER_BIT cycles.
- NEXT: decrement the counter. If the counter was 1: go to IDLE, busy=0, done=1 for one cycle. Otherwise: ram_addra <= ram_addra + 1 with natural wrap 65535 to 0, then go to RD_WAIT.
- Per-byte cost: RD_LAT + 2 overhead cycles plus 10*CLKS_PER_BIT bit cycles; no gap on tx beyond the overhead cycles.
- The baud counter is reloaded at every bit boundary, so bit widths are exact.
- start while busy=1 is ignored. start_addr and end_addr are not re-sampled mid-transfer.
- end_addr < start_addr: the range wraps through 65535 to 0. end_addr == start_addr sends exactly one byte.
- ram_douta is ignored outside LOAD. ram_addra is held stable between address changes.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between DATA and STOP, held CLKS_PER_BIT cycles (state PARITY). Per-byte bit time becomes 11*CLKS_PER_BIT.
- Undefined: no PARITY state; plain 8N1.

Decomposition:
- Package uart_pkg holds:
  - CLKS_PER_BIT default and the derived baud-counter width, $clog2(CLKS_PER_BIT).
  - The FSM state encoding (localparams).
  - Constants TX_IDLE=1'b1 and START_BIT=1'b0.
- Sub-module uart_tx_core: byte serialiser with byte_in/valid/ready, tx output and the parity macro. ram_uart_tx keeps the RAM sequencing and counter FSM, handing bytes over on valid&ready.
- The top-level FSM collapses to IDLE/RD_WAIT/LOAD/SEND/NEXT when this split is used.

Test Plan (CLKS_PER_BIT=4, RD_LAT=1, RAM preloaded):
- Single byte: RAM[0x0010]=0xA5; start with start=end=0x0010 -> tx frame 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; one done pulse; busy low afterwards.
- Three bytes: RAM[0x0100..0x0102]=0x11,0x22,0x33; start_addr=0x0100, end_addr=0x0102 -> three frames in order, ram_addra steps 0x0100 to 0x0102, exactly one done after the third stop bit.
- Wrap: RAM[0xFFFF]=0xDF, RAM[0x0000]=0x01; start_addr=0xFFFF, end_addr=0x0000 -> bytes 0xDF then 0x01; ram_addra goes 0xFFFF to 0x0000.
- Ignored start: pulse start with start_addr=0x0200 during the second byte of a transfer -> no change in sequence or address, single done.
- Reset mid-frame: drive rsta=0 during DATA bit 3 -> tx=1, busy=0 within the same cycle (asynchronous); no done; a new start after release works normally.
- UART_PARITY_EN defined: send 0x07 -> parity bit 1 before the stop bit; frame length 44 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: constants, state encodings and width helper for the RAM-to-UART dump path (UART_PARITY_EN adds the parity state)
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT_DEF);

  localparam logic TX_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  typedef enum logic [2:0] {IDLE, RD_WAIT, LOAD, SEND, NEXT} seq_state_e;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {C_IDLE, C_START, C_DATA, C_PARITY, C_STOP} tx_state_e;
`else
  typedef enum logic [1:0] {C_IDLE, C_START, C_DATA, C_STOP} tx_state_e;
`endif

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: byte serialiser, 8N1 LSB first; with UART_PARITY_EN an even-parity bit precedes the stop bit
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic [DATA_W-1:0] byte_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              last_o,
  output logic              tx_o
);

  localparam int BW = cnt_w(CLKS_PER_BIT);
  localparam int IW = cnt_w(DATA_W);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_MAX = IW'(DATA_W - 1);

  tx_state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [IW-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic par_q, par_d;
  logic tx_q, tx_d;
  logic bit_end;

  assign bit_end = baud_q == BAUD_MAX;
  assign ready_o = state_q == C_IDLE;
  assign last_o = (state_q == C_STOP) && bit_end;
  assign tx_o = tx_q;

  // frame registers; tx is registered so the line is glitch-free and returns high on reset
  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      state_q <= C_IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      tx_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_q <= par_d;
      tx_q <= tx_d;
    end
  end

  // next frame state; the baud counter restarts at every bit boundary so each bit is exactly CLKS_PER_BIT wide
  always_comb begin
    state_d = state_q;
    baud_d = bit_end ? '0 : baud_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    par_d = par_q;
    tx_d = tx_q;
    case (state_q)
      C_IDLE: begin
        baud_d = '0;
        if (valid_i) begin
          state_d = C_START;
          shift_d = byte_i;
          par_d = ^byte_i;
          tx_d = START_BIT;
        end
      end
      C_START: if (bit_end) begin
        state_d = C_DATA;
        bit_d = '0;
        tx_d = shift_q[0];
      end
      C_DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 1'b1;
        if (bit_q == BIT_MAX) begin
`ifdef UART_PARITY_EN
          state_d = C_PARITY;
          tx_d = par_q;
`else
          state_d = C_STOP;
          tx_d = TX_IDLE;
`endif
        end else begin
          tx_d = shift_q[1];
        end
      end
`ifdef UART_PARITY_EN
      C_PARITY: if (bit_end) begin
        state_d = C_STOP;
        tx_d = TX_IDLE;
      end
`endif
      C_STOP: if (bit_end) state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

endmodule

// File: rtl/ram_uart_tx.sv
// ram_uart_tx: dumps data_ram[start_addr..end_addr] (wrapping through 0) onto a UART TX line; UART_PARITY_EN adds even parity
module ram_uart_tx
  import uart_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] ram_addra,
  output logic              ram_wea,
  input  logic [DATA_W-1:0] ram_douta,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int LW = cnt_w(RD_LAT);
  localparam logic [LW-1:0] LAT_MAX = LW'(RD_LAT - 1);
  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

  seq_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [LW-1:0] lat_q, lat_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic core_valid, core_ready, core_last;

  assign ram_addra = addr_q;
  assign ram_wea = 1'b0;
  assign busy = busy_q;
  assign done = done_q;

  uart_tx_core #(
    .DATA_W(DATA_W),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clka(clka),
    .rsta(rsta),
    .byte_i(ram_douta),
    .valid_i(core_valid),
    .ready_o(core_ready),
    .last_o(core_last),
    .tx_o(tx)
  );

  // sequencer registers; an asynchronous reset aborts any transfer without a done pulse
  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      state_q <= IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      lat_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      lat_q <= lat_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // RAM sequencing: wait out the read latency, hand the byte to the serialiser, advance until the count runs out
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    lat_d = lat_q;
    busy_d = busy_q;
    done_d = 1'b0;
    core_valid = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = RD_WAIT;
        addr_d = start_addr;
        cnt_d = {1'b0, end_addr - start_addr} + ONE;
        lat_d = '0;
        busy_d = 1'b1;
      end
      RD_WAIT: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LAT_MAX) begin
          state_d = LOAD;
          lat_d = '0;
        end
      end
      LOAD: begin
        core_valid = 1'b1;
        if (core_ready) state_d = SEND;
      end
      SEND: if (core_last) state_d = NEXT;
      NEXT: begin
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) begin
          state_d = IDLE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
          state_d = RD_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
